// File: rtl/simmem_pkg.sv
// Shared simulated-memory parameters: response bank capacities used to size
// per-bank instances such as the release scheduler.
package simmem_pkg;

    localparam int unsigned WriteRespBankCapacity = 16;
    localparam int unsigned ReadDataBankCapacity  = 16;

endpackage

// File: rtl/simmem_rr_picker.sv
// Combinational round-robin picker: lowest set request at or above the pointer,
// wrapping to the lowest set request overall when nothing lies above it.
module simmem_rr_picker #(
    parameter int unsigned Width    = 16,
    parameter int unsigned IdxWidth = $clog2(Width)
) (
    input  logic [Width-1:0]    req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [Width-1:0]    pick_onehot_o,
    output logic [IdxWidth-1:0] pick_idx_o,
    output logic                pick_any_o
);

    logic [2*Width-1:0] req_dbl;
    logic [2*Width-1:0] req_masked;

    // The upper copy is unmasked so a search that runs past the top of the
    // lower copy naturally lands on the wrapped-around lowest request.
    always_comb begin
        req_dbl    = {req_i, req_i};
        req_masked = '0;
        for (int i = 0; i < 2 * int'(Width); i++) begin
            req_masked[i] = req_dbl[i] && (i >= int'(ptr_i));
        end
    end

    always_comb begin
        pick_any_o = 1'b0;
        pick_idx_o = '0;
        for (int i = 0; i < 2 * int'(Width); i++) begin
            if (req_masked[i] && !pick_any_o) begin
                pick_any_o = 1'b1;
                pick_idx_o = IdxWidth'(i);
            end
        end
        pick_onehot_o = pick_any_o ? (Width'(1) << pick_idx_o) : '0;
    end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Turns the multi-hot release-enable vector of one response bank into a
// stream of single-slot, round-robin release grants with valid/ready handshake.
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int unsigned Capacity = WriteRespBankCapacity,
    parameter int unsigned IdxWidth = $clog2(Capacity)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Capacity-1:0] release_en_i,
    output logic                grant_valid_o,
    output logic [Capacity-1:0] grant_onehot_o,
    output logic [IdxWidth-1:0] grant_idx_o,
    input  logic                grant_ready_i,
    output logic [Capacity-1:0] released_onehot_o
);

    logic                grant_valid_q, grant_valid_d;
    logic [Capacity-1:0] grant_onehot_q, grant_onehot_d;
    logic [IdxWidth-1:0] grant_idx_q, grant_idx_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic [Capacity-1:0] last_rel_q, last_rel_d;

    logic                hs;
    logic [Capacity-1:0] cand;
    logic [Capacity-1:0] pick_onehot;
    logic [IdxWidth-1:0] pick_idx;
    logic                pick_any;

    // Slots released now or last cycle may still show a stale enable because
    // the delay calculator clears them one cycle after seeing the feedback.
    always_comb begin
        hs                = grant_valid_q && grant_ready_i;
        released_onehot_o = hs ? grant_onehot_q : '0;
        cand              = release_en_i & ~last_rel_q & ~released_onehot_o;
    end

    simmem_rr_picker #(
        .Width    (Capacity),
        .IdxWidth (IdxWidth)
    ) u_picker (
        .req_i         (cand),
        .ptr_i         (ptr_q),
        .pick_onehot_o (pick_onehot),
        .pick_idx_o    (pick_idx),
        .pick_any_o    (pick_any)
    );

    always_comb begin
        grant_valid_d  = grant_valid_q;
        grant_onehot_d = grant_onehot_q;
        grant_idx_d    = grant_idx_q;
        ptr_d          = ptr_q;
        last_rel_d     = released_onehot_o;

        if (hs || !grant_valid_q) begin
            grant_valid_d  = pick_any;
            grant_onehot_d = pick_onehot;
            grant_idx_d    = pick_idx;
        end

        if (hs) begin
            ptr_d = grant_idx_q + IdxWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            grant_idx_q    <= '0;
            ptr_q          <= '0;
            last_rel_q     <= '0;
        end else begin
            grant_valid_q  <= grant_valid_d;
            grant_onehot_q <= grant_onehot_d;
            grant_idx_q    <= grant_idx_d;
            ptr_q          <= ptr_d;
            last_rel_q     <= last_rel_d;
        end
    end

    assign grant_valid_o  = grant_valid_q;
    assign grant_onehot_o = grant_onehot_q;
    assign grant_idx_o    = grant_idx_q;

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Scoreboard bench for simmem_release_scheduler: directed scenarios followed by
// random enables, back-pressure and resets checked against a behavioural model.
module tb_simmem_release_scheduler;

    localparam int C  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [C-1:0]  release_en_i = '0;
    logic          grant_ready_i = 1'b0;
    logic          grant_valid_o;
    logic [C-1:0]  grant_onehot_o;
    logic [IW-1:0] grant_idx_o;
    logic [C-1:0]  released_onehot_o;

    always #5 clk = ~clk;

    simmem_release_scheduler #(.Capacity(C)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .release_en_i      (release_en_i),
        .grant_valid_o     (grant_valid_o),
        .grant_onehot_o    (grant_onehot_o),
        .grant_idx_o       (grant_idx_o),
        .grant_ready_i     (grant_ready_i),
        .released_onehot_o (released_onehot_o)
    );

    typedef struct {
        logic          v;
        logic [IW-1:0] idx;
        logic [C-1:0]  oh;
        logic [C-1:0]  rel;
        logic [IW-1:0] ptr;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state: granted slot (-1 = none), rotating pointer,
    // slot released last cycle, and the upstream enable set with its clear pipe.
    int           m_grant;
    int           m_ptr;
    logic [C-1:0] m_last;
    logic [C-1:0] up_en, clr1, clr2;

    task automatic model_reset();
        m_grant = -1;
        m_ptr   = 0;
        m_last  = '0;
        up_en   = '0;
        clr1    = '0;
        clr2    = '0;
    endtask

    task automatic cycle(input logic [C-1:0] add, input logic rdy, input logic rstn, input bit lag1);
        exp_t         e;
        logic [C-1:0] cand;
        bit           hs;
        int           old_ptr;
        @(negedge clk);
        up_en = (up_en & ~clr1) | add;
        clr1  = clr2;
        clr2  = '0;
        if (!rstn) up_en = '0;
        release_en_i  = up_en;
        grant_ready_i = rdy;
        rst_ni        = rstn;

        e.v   = (m_grant >= 0);
        e.idx = e.v ? IW'(m_grant) : '0;
        e.oh  = e.v ? (C'(1) << m_grant) : '0;
        hs    = e.v && rdy;
        e.rel = hs ? e.oh : '0;
        e.ptr = IW'(m_ptr);
        sb_q.push_back(e);

        if (!rstn) begin
            model_reset();
            return;
        end
        for (int i = 0; i < C; i++)
            cand[i] = up_en[i] && !m_last[i] && !(hs && i == m_grant);
        old_ptr = m_ptr;
        if (hs) m_ptr = (m_grant + 1) % C;
        if (hs || !e.v) begin
            m_grant = -1;
            for (int k = 0; k < C; k++) begin
                if (m_grant < 0 && cand[(old_ptr + k) % C]) m_grant = (old_ptr + k) % C;
            end
        end
        m_last = e.rel;
        if (lag1) clr1 = clr1 | e.rel;
        else      clr2 = clr2 | e.rel;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            vectors++;
            if (grant_valid_o !== mon_e.v || grant_idx_o !== mon_e.idx ||
                grant_onehot_o !== mon_e.oh || released_onehot_o !== mon_e.rel ||
                dut.ptr_q !== mon_e.ptr) begin
                miscompares++;
                $display("FAIL grant t=%0t: got v=%b idx=%0d oh=%h rel=%h ptr=%0d, want v=%b idx=%0d oh=%h rel=%h ptr=%0d",
                         $time, grant_valid_o, grant_idx_o, grant_onehot_o, released_onehot_o, dut.ptr_q,
                         mon_e.v, mon_e.idx, mon_e.oh, mon_e.rel, mon_e.ptr);
            end
            if (rst_ni && grant_valid_o) begin
                vectors++;
                if (release_en_i[grant_idx_o] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL enable_contract t=%0t: slot %0d enable=%b, want 1",
                             $time, grant_idx_o, release_en_i[grant_idx_o]);
                end
            end
        end
    end

    initial begin
        model_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        cycle('0, 1'b0, 1'b0, 1'b0);

        // Single slot: latency and one-cycle feedback pulse.
        cycle(16'h0001, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle('0, 1'b1, 1'b1, 1'b0);

        // All slots enabled: 0..15 back to back.
        cycle(16'hFFFF, 1'b1, 1'b1, 1'b0);
        repeat (18) cycle('0, 1'b1, 1'b1, 1'b0);

        // Back-pressure hold, then release 0 and 2.
        cycle(16'h0005, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle('0, 1'b0, 1'b1, 1'b0);
        repeat (4) cycle('0, 1'b1, 1'b1, 1'b0);

        // Pointer at 14 after releasing 13, then wrap to 0.
        cycle(16'h2000, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle('0, 1'b1, 1'b1, 1'b0);
        cycle(16'h4001, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle('0, 1'b1, 1'b1, 1'b0);

        // Stale enable on slot 3 while slot 7 rises during its handshake.
        cycle(16'h0008, 1'b1, 1'b1, 1'b0);
        cycle(16'h0080, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle('0, 1'b1, 1'b1, 1'b0);

        // Reset while a grant on slot 5 is held.
        cycle(16'h0020, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle('0, 1'b0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle('0, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [C-1:0] add;
            add = ($urandom_range(0, 2) == 0) ? C'($urandom & $urandom & $urandom) : '0;
            cycle(add, ($urandom_range(0, 3) != 0), ($urandom_range(0, 127) != 0),
                  ($urandom_range(0, 3) == 0));
        end
        repeat (20) cycle('0, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        #4;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/simmem_release_scheduler.md
# simmem_release_scheduler

Sits between the delay calculator and one response bank (write-response or read-data) and turns the multi-hot release-enable vector into a sequence of single-slot release grants. A message bank releases at most one slot per cycle, so the block picks one eligible slot round-robin, holds it stable under back-pressure, and pulses the released-slot feedback that the delay calculator uses to clear its enable. One instance serves the write-response bank; another serves the read-data bank.

## Interface
- Capacity, default 16: number of bank slots; must be ≥2 and a power of two.
- IdxWidth, default $clog2(Capacity): slot index width. Derived; do not override.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- release_en_i  in  Capacity  multi-hot slots whose delay has elapsed. Driven by the delay calculator.
- grant_valid_o  out  1  a slot release is offered to the bank.
- grant_onehot_o  out  Capacity  one-hot slot offered. All-zero when grant_valid_o is 0.
- grant_idx_o  out  IdxWidth  binary index of grant_onehot_o. Zero when not valid.
- grant_ready_i  in  1  bank accepts the offered release this cycle.
- released_onehot_o  out  Capacity  feedback to the delay calculator; equals grant_onehot_o during a handshake, else zero.

## Operation
- Handshake: a handshake occurs in a cycle where grant_valid_o and grant_ready_i are both 1.
- Grant hold: once grant_valid_o is 1, grant_onehot_o and grant_idx_o stay constant until the handshake.
  - release_en_i for the granted slot must not drop before the handshake. This is an upstream contract and the bench checks it.
- Candidate vector: cand = release_en_i & ~last_rel_q & ~(hs ? grant_onehot_q : 0).
  - last_rel_q is a register loaded with released_onehot_o every cycle.
  - Purpose: mask slots whose enable is still high because the delay calculator clears them one cycle after feedback.
- Pick: take the lowest index ≥ ptr_q in cand. If none exists, wrap to the lowest set index in cand.
- Grant register update:
  - On handshake, or when the grant register is empty: load the pick. Set valid = |cand.
  - Otherwise: hold the current grant.
- Pointer: on handshake of slot k, ptr_q ← (k+1) mod Capacity, using natural IdxWidth wrap. Otherwise ptr_q holds.
- released_onehot_o is combinational from the registered grant and grant_ready_i.
- Reset values: grant_valid_o=0, grant_onehot_o=0, grant_idx_o=0, released_onehot_o=0, ptr_q=0, last_rel_q=0.

## Timing
- Latency: a slot enabled at cycle t, with an idle scheduler, shows grant_valid_o at t+1.
- Throughput: one release per cycle sustained. On a handshake at t, the next grant is valid at t+1 if cand at t is non-zero.
- Re-grant spacing: a released slot cannot be re-granted before t+2. Masking covers t (current grant) and t+1 (last_rel_q).
- Back-pressure with grant_ready_i=0: the grant is held indefinitely. New enables accumulate, and the pointer does not move.
- Empty case: release_en_i=0 with no grant held gives grant_valid_o=0 and all outputs zero.
- Wrap-around: with ptr_q=Capacity-1 and that slot not a candidate, the lowest set slot is picked.
- Reset mid-operation: a held grant is dropped with no released_onehot_o pulse. The bank and the delay calculator are reset in the same cycle.
- Concurrency: an enable rising in the same cycle as a handshake takes part in that cycle's pick.

## Structure
- simmem_pkg: reuse WriteRespBankCapacity and ReadDataBankCapacity as instance parameters. No new typedefs are needed.
- Sub-module simmem_rr_picker: combinational. Inputs: req vector and pointer. Outputs: one-hot pick, index, any.
  - Implemented as a double-width priority search over {req, req} masked by the pointer.
- The top level holds the grant, pointer and last_rel_q registers and the handshake logic.

## Test plan
- Reset, then release_en_i=16'h0001 at cycle 1 → grant_valid_o=1, grant_idx_o=0 at cycle 2. With ready=1, released_onehot_o=16'h0001 at cycle 2 and grant_valid_o=0 at cycle 3.
- release_en_i=16'hFFFF held, with upstream clearing each bit one cycle after feedback, ready=1 → grants 0,1,…,15 on consecutive cycles, each index exactly once.
- release_en_i=16'h0005, ready=0 for 5 cycles → grant_idx_o=0 stable all 5 cycles, no feedback pulse. When ready rises → release 0, then 2 next cycle.
- ptr_q=14 (after releasing 13), release_en_i=16'h4001 → grant 14, then 0 (wrap).
- Handshake on slot 3 while slot 3's enable stays high one extra cycle and slot 7 rises in the same cycle → next grant 7, never 3 twice.
- Grant on slot 5 held with ready=0, rst_ni=0 for one cycle → all outputs zero the next cycle, no released_onehot_o pulse, ptr_q=0.
